// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Instruction encoder used by the program loader / self-test sequencer. Packs
// decoded fields (format, opcode, funct3/funct7, rd/rs1/rs2, immediate) into a
// 32-bit RISC-V instruction, flags immediates that cannot be represented, and
// tags each instruction with a sequential imem word address. Results are
// queued in a small output FIFO.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clr               synchronous clear (same effect as rst)
//   in_valid/ready    request handshake
//   in_fmt            00=I 01=S 10=B 11=U
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm
//                     decoded instruction fields
//   out_valid/ready   FIFO head handshake
//   out_inst          encoded instruction at head
//   out_addr          imem word address at head
//   out_err           head immediate was out of range / misaligned
//   err_count         saturating count of accepted erroneous requests
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] FMT_I  = 2'b00;
    localparam logic [1:0] FMT_S  = 2'b01;
    localparam logic [1:0] FMT_B  = 2'b10;
    localparam logic [1:0] FMT_U  = 2'b11;
    localparam logic [6:0] OP_IMM = 7'h13;

    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DEPTH-1:0]  err_mem;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        err_cnt;

    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              is_shift_c;
    logic              fits12_c;
    logic              fits13_c;
    logic [31:0]       enc_inst_c;
    logic              enc_err_c;

    // Handshake; no write-through when full even if the head is being popped
    assign full_c    = (count == CNT_W'(DEPTH));
    assign in_ready  = !full_c;
    assign out_valid = (count != '0);
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    // Head is read straight from registered storage
    assign out_inst  = inst_mem[rd_ptr];
    assign out_addr  = addr_mem[rd_ptr];
    assign out_err   = err_mem[rd_ptr];
    assign err_count = err_cnt;

    // Immediate scatter and range / alignment check
    always_comb begin
        enc_inst_c = '0;
        enc_err_c  = 1'b0;
        is_shift_c = (in_opcode == OP_IMM) &&
                     ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
        // upper bits must be pure sign extension of the encodable field
        fits12_c   = (in_imm[31:11] == {21{in_imm[11]}});
        fits13_c   = (in_imm[31:12] == {20{in_imm[12]}});
        case (in_fmt)
            FMT_I: begin
                if (is_shift_c) begin
                    enc_inst_c = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_err_c  = |in_imm[31:5];
                end else begin
                    enc_inst_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_err_c  = !fits12_c;
                end
            end
            FMT_S: begin
                enc_inst_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err_c  = !fits12_c;
            end
            FMT_B: begin
                enc_inst_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
                enc_err_c  = !fits13_c || in_imm[0];
            end
            FMT_U: begin
                enc_inst_c = {in_imm[31:12], in_rd, in_opcode};
                enc_err_c  = |in_imm[11:0];
            end
        endcase
    end

    // FIFO storage; cleared so an empty FIFO presents zeros at the head
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
            err_mem <= '0;
        end else if (push_c) begin
            inst_mem[wr_ptr] <= enc_inst_c;
            addr_mem[wr_ptr] <= addr_cnt;
            err_mem[wr_ptr]  <= enc_err_c;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address counter and saturating error counter
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr_cnt <= '0;
            err_cnt  <= '0;
        end else if (push_c) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (enc_err_c && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder. Two instances share all inputs: one
// with the default 10-bit address counter and one with a 2-bit counter to
// exercise wrap-around. A queue-based reference model tracks expected FIFO
// contents, addresses and the error count.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [9:0]  out_addr;
    logic [7:0]  err_count;

    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_inst2;
    logic [1:0]  out_addr2;
    logic [7:0]  err_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
        .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        int          addr;
        logic        err;
    } ent_t;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    ent_t q[$];
    int   m_addr   = 0;
    int   m_errcnt = 0;

    // Encoding from the instruction-format tables; legality via signed ranges
    function automatic ent_t model_encode(input logic [1:0] fmt, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
        ent_t e;
        int   s;
        s      = $signed(imm);
        e.addr = 0;
        e.inst = '0;
        e.err  = 1'b0;
        case (fmt)
            2'd0: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    e.inst = {f7, imm[4:0], rs1, f3, rd, op};
                    e.err  = (imm > 32'd31);
                end else begin
                    e.inst = {imm[11:0], rs1, f3, rd, op};
                    e.err  = (s < -2048) || (s > 2047);
                end
            end
            2'd1: begin
                e.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e.err  = (s < -2048) || (s > 2047);
            end
            2'd2: begin
                e.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e.err  = (s < -4096) || (s > 4094) || ((s % 2) != 0);
            end
            default: begin
                e.inst = {imm[31:12], rd, op};
                e.err  = (imm % 32'd4096) != 32'd0;
            end
        endcase
        return e;
    endfunction

    bit   m_acc, m_pop;
    ent_t m_e;
    always @(posedge clk) begin
        if (rst || clr) begin
            q.delete();
            m_addr   = 0;
            m_errcnt = 0;
        end else begin
            m_acc = in_valid && (q.size() < DEPTH);
            m_pop = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                m_e = model_encode(in_fmt, in_opcode, in_funct3, in_funct7,
                                   in_rd, in_rs1, in_rs2, in_imm);
                m_e.addr = m_addr;
                q.push_back(m_e);
                m_addr = m_addr + 1;
                if (m_e.err && m_errcnt < 255) m_errcnt = m_errcnt + 1;
            end
        end
    end

    // Directed vectors with hand-derived encodings
    function automatic vec_t get_vec(input int i);
        vec_t v;
        case (i)
            0: v = '{2'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0};
            1: v = '{2'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0};
            2: v = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0};
            3: v = '{2'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0};
            4: v = '{2'd0, 7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd4,         32'h4041D193, 1'b0};
            5: v = '{2'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h80000093, 1'b1};
            6: v = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd6,         32'h00208363, 1'b0};
            default: v = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7,  32'h00208363, 1'b1};
        endcase
        return v;
    endfunction

    task automatic set_req(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    task automatic do_clr();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 10'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h addr=%0d err=%b, required 0/0/0/0",
                     out_valid, out_inst, out_addr, out_err);
        end
        checks++;
        if (in_ready !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b err_count=%0d, required 1/0", in_ready, err_count);
        end
    endtask

    task automatic run_vectors(input string name, input int first, input int last);
        vec_t v;
        do_clr();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: out_valid=%b, required 0", name, out_valid);
        end
        for (int i = first; i <= last; i++) begin
            v = get_vec(i);
            set_req(v);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_inst !== v.exp_inst || out_err !== v.exp_err) begin
                errors++;
                $display("FAIL %s_vec%0d: valid=%b inst=%h err=%b, required 1/%h/%b",
                         name, i, out_valid, out_inst, out_err, v.exp_inst, v.exp_err);
            end
            checks++;
            if (out_addr !== 10'(i - first) || out_addr2 !== 2'(i - first) || out_inst2 !== v.exp_inst) begin
                errors++;
                $display("FAIL %s_addr%0d: addr=%0d addr2=%0d inst2=%h, required %0d/%0d/%h",
                         name, i, out_addr, out_addr2, out_inst2, i - first, (i - first) % 4, v.exp_inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_encode();
        run_vectors("encode", 0, 4);
    endtask

    task automatic test_errors();
        run_vectors("errors", 5, 7);
        @(negedge clk);
        checks++;
        if (err_count !== 8'd2 || err_count2 !== 8'd2) begin
            errors++;
            $display("FAIL err_count: got %0d/%0d, required 2", err_count, err_count2);
        end
    endtask

    task automatic test_backpressure();
        int exp_a [5] = '{0, 0, 0, 1, 2};
        bit exp_r [5] = '{1, 0, 0, 1, 1};
        do_clr();
        out_ready = 1'b0;
        @(negedge clk);
        set_req(get_vec(0));
        for (int c = 0; c < 5; c++) begin
            if (c == 3) out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (c == 4) in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 10'(exp_a[c]) || in_ready !== exp_r[c]) begin
                errors++;
                $display("FAIL backpressure_c%0d: valid=%b addr=%0d in_ready=%b, required 1/%0d/%b",
                         c, out_valid, out_addr, in_ready, exp_a[c], exp_r[c]);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_clr();
        out_ready = 1'b1;
        @(negedge clk);
        set_req(get_vec(3));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid2 !== 1'b1 || out_addr2 !== 2'(k % 4) || out_addr !== 10'(k)) begin
                errors++;
                $display("FAIL wrap_k%0d: valid2=%b addr2=%0d addr=%0d, required 1/%0d/%0d",
                         k, out_valid2, out_addr2, out_addr, k % 4, k);
            end
        end
        // refill, then clear with entries pending
        out_ready = 1'b0;
        set_req(get_vec(5));
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        do_clr();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_valid2 !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_mid: valid=%b valid2=%b in_ready=%b err_count=%0d, required 0/0/1/0",
                     out_valid, out_valid2, in_ready, err_count);
        end
        set_req(get_vec(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 10'd0 || out_addr2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_addr: valid=%b addr=%0d addr2=%0d, required 1/0/0",
                     out_valid, out_addr, out_addr2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        do_clr();
        out_ready = 1'b1;
        @(negedge clk);
        set_req(get_vec(7));
        repeat (260) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_count !== 8'd255 || err_count2 !== 8'd255 || m_errcnt != 255) begin
            errors++;
            $display("FAIL err_saturate: got %0d/%0d model %0d, required 255",
                     err_count, err_count2, m_errcnt);
        end
    endtask

    task automatic test_random();
        ent_t h;
        int   sel;
        do_clr();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH) ||
                err_count !== 8'(m_errcnt) || err_count2 !== 8'(m_errcnt)) begin
                errors++;
                $display("FAIL rand_ctl%0d: valid=%b in_ready=%b err_count=%0d, required %b/%b/%0d",
                         i, out_valid, in_ready, err_count, q.size() != 0, q.size() < DEPTH, m_errcnt);
            end
            if (q.size() != 0) begin
                h = q[0];
                checks++;
                if (out_inst !== h.inst || out_err !== h.err || out_addr !== 10'(h.addr % 1024) ||
                    out_inst2 !== h.inst || out_addr2 !== 2'(h.addr % 4)) begin
                    errors++;
                    $display("FAIL rand_head%0d: inst=%h err=%b addr=%0d addr2=%0d, required %h/%b/%0d/%0d",
                             i, out_inst, out_err, out_addr, out_addr2, h.inst, h.err,
                             h.addr % 1024, h.addr % 4);
                end
            end
            clr       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_fmt    = 2'($urandom_range(0, 3));
            in_opcode = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            sel       = $urandom_range(0, 3);
            case (sel)
                0: in_imm = $urandom;
                1: in_imm = 32'($urandom_range(0, 8200)) - 32'd4100;
                2: in_imm = $urandom & 32'hFFFFF000;
                default: in_imm = 32'($urandom_range(0, 40));
            endcase
        end
        clr      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_errors();
        test_backpressure();
        test_wrap();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
